// File: rtl/spi_regfile.sv
// SPI-mode-0 slave exposing a small bank of read/write registers.
// Frames are [R/W][address MSB-first][data MSB-first]. All SPI pins are
// resynchronized into clk; sclk edges are found by comparing the
// synchronized sclk with its previous value.
module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       sdi,
  input  logic                       cs_n,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_DATA0 = CNT_W'(ADDR_W + 1);
  localparam logic [ADDR_W:0]   NREGS     = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 sclk_meta, sclk_sync, sclk_prev;
  logic                 sdi_meta, sdi_sync;
  logic                 cs_meta, cs_sync;
  logic [1:0]           settle_reg;
  logic                 armed_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [FRAME_W-1:0]   shift_reg;
  logic [DATA_W-1:0]    out_reg;
  logic [DATA_W-1:0]    reg_mem [NUM_REGS];
  logic                 wr_pulse_reg, frame_err_reg;
  logic [ADDR_W-1:0]    wr_addr_reg;

  logic                 sclk_rise, sclk_fall;
  logic [FRAME_W-1:0]   shift_val;
  logic                 rd_rw;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    rd_word;
  logic                 fr_rw;
  logic [ADDR_W-1:0]    fr_addr;
  logic [DATA_W-1:0]    fr_data;
  logic                 fr_full, commit, read_ok, reject;

  // Two-flop synchronizers; cs_n idles deasserted (high) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      sdi_meta  <= 1'b0;
      sdi_sync  <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      sdi_meta  <= sdi;
      sdi_sync  <= sdi_meta;
      cs_meta   <= cs_n;
      cs_sync   <= cs_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;

  // Arm only after cs_n has been seen high through a refilled synchronizer,
  // so a frame cut by reset is never picked up halfway after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_reg <= 2'b00;
      armed_reg  <= 1'b0;
    end else begin
      settle_reg <= {settle_reg[0], 1'b1};
      if (settle_reg[1] && cs_sync)
        armed_reg <= 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: DONE lasts exactly one clk.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (armed_reg && !cs_sync) state_next = SHIFT;
      SHIFT:   if (cs_sync)               state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read-address decode on the sclk rise that delivers the last address bit.
  always_comb begin
    shift_val = {shift_reg[FRAME_W-2:0], sdi_sync};
    rd_rw     = shift_val[ADDR_W];
    rd_addr   = shift_val[ADDR_W-1:0];
    rd_word   = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_word = reg_mem[i];
  end

  // Completed-frame decode, evaluated while in DONE.
  always_comb begin
    fr_rw   = shift_reg[FRAME_W-1];
    fr_addr = shift_reg[FRAME_W-2 -: ADDR_W];
    fr_data = shift_reg[DATA_W-1:0];
    fr_full = (count_reg == CNT_FULL);
    commit  = (state_reg == DONE) && fr_full && fr_rw && ({1'b0, fr_addr} < NREGS);
    read_ok = (state_reg == DONE) && fr_full && !fr_rw;
    reject  = (state_reg == DONE) && !commit && !read_ok;
  end

  // Shift/count/readback datapath. The fall right after the address load
  // leaves the MSB in place so the master samples it on the first data rise;
  // later falls advance one bit each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      shift_reg <= '0;
      out_reg   <= '0;
    end else begin
      case (state_reg)
        SHIFT: begin
          if (cs_sync) begin
            out_reg <= '0;
          end else if (sclk_rise) begin
            shift_reg <= shift_val;
            if (count_reg != CNT_SAT) count_reg <= count_reg + CNT_W'(1);
            if (count_reg == CNT_ADDR) out_reg <= rd_rw ? '0 : rd_word;
          end else if (sclk_fall && (count_reg > CNT_DATA0)) begin
            out_reg <= out_reg << 1;
          end
        end
        DONE: out_reg <= '0;
        default: begin
          count_reg <= '0;
          shift_reg <= '0;
          out_reg   <= '0;
        end
      endcase
    end
  end

  // Register bank write and write/error strobes, all on the DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) reg_mem[i] <= '0;
      wr_pulse_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= '0;
    end else begin
      wr_pulse_reg  <= commit;
      frame_err_reg <= reject;
      if (commit) begin
        wr_addr_reg <= fr_addr;
        for (int i = 0; i < NUM_REGS; i++)
          if (fr_addr == ADDR_W'(i)) reg_mem[i] <= fr_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      assign regs[gi*DATA_W +: DATA_W] = reg_mem[gi];
    end
  endgenerate

  assign sdo       = out_reg[DATA_W-1];
  assign wr_pulse  = wr_pulse_reg;
  assign wr_addr   = wr_addr_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 Parameter NUM_REGS, default 5: number of writable/readable registers, range 1..2**ADDR_W.
REQ-002 Parameter DATA_W, default 8: register width in bits.
REQ-003 Parameter ADDR_W, default 7: address field width; frame width FRAME_W = 1 + ADDR_W + DATA_W (16 at defaults).
REQ-004 clk  input  1  system clock; all logic on rising edge; clk frequency SHALL be at least 8x sclk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sclk  input  1  SPI serial clock, async to clk, mode 0 (idle low, sample on rise, shift on fall).
REQ-007 sdi  input  1  SPI serial data in, MSB first.
REQ-008 cs_n  input  1  SPI chip select, active-low, async to clk.
REQ-009 sdo  output  1  SPI serial data out, read frames only.
REQ-010 regs  output  NUM_REGS*DATA_W  flat register bus; register i occupies bits [i*DATA_W +: DATA_W].
REQ-011 wr_pulse  output  1  one-clk strobe on each committed write.
REQ-012 wr_addr  output  ADDR_W  address of the last committed write, valid with wr_pulse and held after it.
REQ-013 frame_err  output  1  one-clk strobe on each rejected frame.

Function
REQ-014 sclk, sdi, cs_n SHALL each pass through a two-flop synchronizer clocked by clk; all other logic uses only synchronized versions.
REQ-015 Rising/falling sclk edges SHALL be detected by comparing the synchronized sclk with its value one clk earlier.
REQ-016 Frame bit 0 (first shifted) = R/W (1 write, 0 read), next ADDR_W bits = address MSB first, last DATA_W bits = data MSB first.
REQ-017 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-018 IDLE -> SHIFT when synchronized cs_n is low; bit counter and shift register cleared on entry.
REQ-019 In SHIFT, each detected sclk rise shifts synchronized sdi into the LSB of a FRAME_W shift register and increments the bit counter.
REQ-020 Bit counter saturates at FRAME_W+1; saturated count marks frame overflow.
REQ-021 SHIFT -> DONE when synchronized cs_n goes high; DONE -> IDLE unconditionally after one clk.
REQ-022 In DONE a write commits iff count == FRAME_W, R/W == 1, address < NUM_REGS: register[address] <= data, wr_pulse = 1, wr_addr <= address, all in the same clk.
REQ-023 In DONE a read frame is accepted iff count == FRAME_W and R/W == 0; no register changes, no pulse.
REQ-024 Any other frame in DONE (short, overflow, write to address >= NUM_REGS, read with wrong count) SHALL assert frame_err for one clk and change no register.
REQ-025 Read: when the last address bit is sampled, a DATA_W output register loads register[address] (zero if address >= NUM_REGS); sdo = its MSB.
REQ-026 On each subsequent detected sclk fall in SHIFT the output register shifts left one bit, zero-filled; sdo follows the MSB.
REQ-027 sdo SHALL be 0 in IDLE, in DONE, and throughout write frames.
REQ-028 A write and a read are never simultaneous; a register written in DONE is visible to the next frame's read.
REQ-029 cs_n rising with no sclk edges (count 0) SHALL produce frame_err.
REQ-030 sclk edges while synchronized cs_n is high SHALL be ignored.

Reset
REQ-031 On rst_n low, immediately: all registers 0, regs = 0, sdo = 0, wr_pulse = 0, wr_addr = 0, frame_err = 0, FSM IDLE, counter and shift registers 0, synchronizer flops 0 (cs_n synchronizer flops 1).
REQ-032 Reset asserted mid-frame SHALL abort the frame with no commit; after release the first frame is decoded only from a fresh cs_n fall.

Verification
REQ-033 Defaults, write frame 0x8155 (R/W=1, addr 1, data 0x55) -> regs[15:8] = 0x55, wr_pulse one clk, wr_addr = 1, frame_err 0.
REQ-034 Write frame 0x85AA (addr 5, NUM_REGS=5) -> frame_err one clk, regs unchanged, no wr_pulse.
REQ-035 15-bit frame, then 17-bit frame, each with R/W=1 addr 2 -> frame_err each, reg 2 unchanged.
REQ-036 After REQ-033, read frame 0x0100 -> sdo shows 0,1,0,1,0,1,0,1 over the 8 data bit periods, sampled on sclk rise; regs unchanged.
REQ-037 rst_n pulsed low after 9 bits of write 0x83FF -> all outputs 0 at once, no commit; following write 0x8312 -> reg 3 = 0x12.
REQ-038 NUM_REGS=16, DATA_W=16, ADDR_W=4: write addr 15 data 0xBEEF -> regs[255:240] = 0xBEEF, wr_addr = 15.
